// File: rtl/random_galois_ranged_pkg.sv
// Shared types and default constants for the ranged Galois random generator.
package random_galois_ranged_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GEN  = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    localparam logic [7:0] DEF_POLY = 8'h8E;
    localparam logic [7:0] DEF_SEED = 8'h32;

endpackage

// File: rtl/random_galois_ranged_lfsr_step.sv
// One combinational Galois LFSR step: shift right, fold POLY in when the dropped bit is 1.
module galois_lfsr_step
    import random_galois_ranged_pkg::*;
#(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] POLY  = WIDTH'(DEF_POLY)
) (
    input  logic [WIDTH-1:0] i_q,
    output logic [WIDTH-1:0] o_q
);

    assign o_q = (i_q >> 1) ^ (i_q[0] ? POLY : '0);

endmodule

// File: rtl/random_galois_ranged.sv
// Ranged random generator: Galois LFSR with mask-and-reject sampling below an exclusive bound,
// with a masked fallback after MAX_TRIES rejections.
//
// state | meaning
// IDLE  | waiting for i_req; bound and mask captured on request
// GEN   | advancing LFSR, testing one candidate per cycle
// HOLD  | result presented until i_ready
module random_galois_ranged
    import random_galois_ranged_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] POLY      = WIDTH'(DEF_POLY),
    parameter logic [WIDTH-1:0] SEED      = WIDTH'(DEF_SEED),
    parameter int               STEPS     = 1,
    parameter int               MAX_TRIES = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_seed_load,
    input  logic [WIDTH-1:0] i_seed,
    input  logic             i_req,
    input  logic [WIDTH-1:0] i_bound,
    input  logic             i_ready,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_random_data,
    output logic             o_busy
);

    localparam int TW = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
    localparam logic [TW-1:0] LAST_TRY = TW'(MAX_TRIES - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] lfsr_q, lfsr_d;
    logic [WIDTH-1:0] bound_q, bound_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [TW-1:0]    tries_q, tries_d;
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             busy_q, busy_d;

    logic [WIDTH-1:0] chain [STEPS+1];
    logic [WIDTH-1:0] cand;
    logic [WIDTH-1:0] bound_m1;
    logic [WIDTH-1:0] mask_calc;

    assign chain[0] = lfsr_q;

    for (genvar g = 0; g < STEPS; g++) begin : g_step
        galois_lfsr_step #(
            .WIDTH (WIDTH),
            .POLY  (POLY)
        ) u_step (
            .i_q (chain[g]),
            .o_q (chain[g+1])
        );
    end

    assign cand = chain[STEPS] & mask_q;

    // Smear the highest set bit of bound-1 downward: smallest 2^k-1 covering bound-1.
    always_comb begin
        bound_m1  = i_bound - WIDTH'(1);
        mask_calc = bound_m1;
        for (int s = 1; s < WIDTH; s = s * 2) begin
            mask_calc = mask_calc | (mask_calc >> s);
        end
        if (i_bound == '0) begin
            mask_calc = '1;
        end
    end

    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        bound_d = bound_q;
        mask_d  = mask_q;
        tries_d = tries_q;
        valid_d = valid_q;
        data_d  = data_q;

        if (i_seed_load) begin
            lfsr_d  = (i_seed == '0) ? SEED : i_seed;
            state_d = ST_IDLE;
            valid_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (i_req) begin
                        bound_d = i_bound;
                        mask_d  = mask_calc;
                        tries_d = '0;
                        state_d = ST_GEN;
                    end
                end
                ST_GEN: begin
                    lfsr_d = chain[STEPS];
                    if (bound_q == '0 || cand < bound_q) begin
                        data_d  = cand;
                        valid_d = 1'b1;
                        state_d = ST_HOLD;
                    end else if (tries_q == LAST_TRY) begin
                        data_d  = cand & (mask_q >> 1);
                        valid_d = 1'b1;
                        state_d = ST_HOLD;
                    end else begin
                        tries_d = tries_q + TW'(1);
                    end
                end
                ST_HOLD: begin
                    if (i_ready) begin
                        valid_d = 1'b0;
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        busy_d = (state_d == ST_GEN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            lfsr_q  <= SEED;
            bound_q <= '0;
            mask_q  <= '0;
            tries_q <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            bound_q <= bound_d;
            mask_q  <= mask_d;
            tries_q <= tries_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
        end
    end

    assign o_valid       = valid_q;
    assign o_random_data = data_q;
    assign o_busy        = busy_q;

endmodule

// File: tb/tb_random_galois_ranged.sv
// Directed bench: instance A uses MAX_TRIES=16, instance B MAX_TRIES=1; both share stimulus.
module tb_random_galois_ranged;

    logic       clk = 1'b0;
    logic       rst;
    logic       i_seed_load;
    logic [7:0] i_seed;
    logic       i_req;
    logic [7:0] i_bound;
    logic       i_ready;
    logic       valid_a, busy_a, valid_b, busy_b;
    logic [7:0] data_a, data_b;

    int errors = 0;
    int checks = 0;
    int cycles;
    logic [7:0] held;

    always #5 clk = ~clk;

    random_galois_ranged #(.MAX_TRIES(16)) u_dut_a (
        .clk           (clk),
        .rst           (rst),
        .i_seed_load   (i_seed_load),
        .i_seed        (i_seed),
        .i_req         (i_req),
        .i_bound       (i_bound),
        .i_ready       (i_ready),
        .o_valid       (valid_a),
        .o_random_data (data_a),
        .o_busy        (busy_a)
    );

    random_galois_ranged #(.MAX_TRIES(1)) u_dut_b (
        .clk           (clk),
        .rst           (rst),
        .i_seed_load   (i_seed_load),
        .i_seed        (i_seed),
        .i_req         (i_req),
        .i_bound       (i_bound),
        .i_ready       (i_ready),
        .o_valid       (valid_b),
        .o_random_data (data_b),
        .o_busy        (busy_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic req(input logic [7:0] b);
        @(negedge clk);
        i_req   = 1'b1;
        i_bound = b;
        @(negedge clk);
        i_req   = 1'b0;
    endtask

    // Counts edges after the request edge until A presents a result (bounded).
    task automatic wait_a(input int max_cycles);
        cycles = 0;
        while (!valid_a && cycles < max_cycles) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic ack();
        @(negedge clk);
        i_ready = 1'b1;
        @(negedge clk);
        i_ready = 1'b0;
    endtask

    task automatic seed(input logic [7:0] s);
        @(negedge clk);
        i_seed_load = 1'b1;
        i_seed      = s;
        @(negedge clk);
        i_seed_load = 1'b0;
    endtask

    initial begin
        rst = 1'b1; i_seed_load = 1'b0; i_seed = '0; i_req = 1'b0;
        i_bound = '0; i_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_valid", valid_a, 1'b0);
        chk("rst_data", data_a, 8'h00);
        chk("rst_busy", busy_a, 1'b0);
        rst = 1'b0;

        // Free-running sequence from SEED with full range
        req(8'd0);
        chk("busy_in_gen", busy_a, 1'b1);
        wait_a(40);
        chk("lat_first", cycles, 1);
        chk("seq0", data_a, 8'h19);
        chk("busy_in_hold", busy_a, 1'b0);
        ack();
        chk("ack_clears", valid_a, 1'b0);
        req(8'd0); wait_a(40); chk("seq1", data_a, 8'h82); ack();
        req(8'd0); wait_a(40); chk("seq2", data_a, 8'h41);
        // i_req on the accepting edge is ignored
        @(negedge clk);
        i_ready = 1'b1; i_req = 1'b1;
        @(negedge clk);
        i_ready = 1'b0; i_req = 1'b0;
        chk("req_in_ack_ignored", busy_a, 1'b0);
        @(negedge clk);
        chk("req_in_ack_novalid", valid_a, 1'b0);

        // Zero seed substitutes SEED
        seed(8'h00);
        req(8'd0); wait_a(40); chk("zero_seed", data_a, 8'h19); ack();

        // Rejection path: candidates 6,7 rejected, 5 accepted; B falls back to 6&3=2
        seed(8'h41);
        req(8'd6);
        @(negedge clk);
        chk("b_fallback_valid", valid_b, 1'b1);
        chk("b_fallback_data", data_b, 8'h02);
        chk("a_still_busy", busy_a, 1'b1);
        cycles = 1;
        while (!valid_a && cycles < 40) begin
            @(negedge clk);
            cycles++;
        end
        chk("reject_lat", cycles, 3);
        chk("reject_data", data_a, 8'h05);
        ack();

        // HOLD stability with i_ready low; bound change outside IDLE has no effect
        req(8'd0);
        i_bound = 8'd3;
        wait_a(40);
        held = data_a;
        chk("hold_data0", data_a, 8'hDC);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_valid", valid_a, 1'b1);
            chk("hold_stable", data_a, held);
        end
        ack();

        // Seed load during GEN drops the request
        seed(8'h41);
        req(8'd6);
        i_seed_load = 1'b1; i_seed = 8'h41;
        @(negedge clk);
        i_seed_load = 1'b0;
        chk("sl_valid", valid_a, 1'b0);
        chk("sl_idle", busy_a, 1'b0);
        chk("sl_b_valid", valid_b, 1'b0);
        @(negedge clk);
        chk("sl_dropped", valid_a, 1'b0);
        req(8'd6); wait_a(40); chk("sl_reload", data_a, 8'h05); ack();

        // Reset during GEN
        seed(8'h41);
        req(8'd6);
        rst = 1'b1;
        #1;
        chk("arst_valid", valid_a, 1'b0);
        chk("arst_data", data_a, 8'h00);
        chk("arst_busy", busy_a, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("post_rst_quiet", valid_a, 1'b0);
        req(8'd0); wait_a(40); chk("post_rst_seed", data_a, 8'h19); ack();

        // Bound 1 gives mask 0: result 0 on first GEN cycle
        req(8'd1); wait_a(40);
        chk("bound1_lat", cycles, 1);
        chk("bound1_data", data_a, 8'h00);
        chk("bound1_valid", valid_a, 1'b1);
        ack();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/random_galois_ranged.md
RANDOM_GALOIS_RANGED -- requirements
Module: random_galois_ranged

Interface
REQ-001 Parameter WIDTH, default 8: LFSR and data width, legal 4..32.
REQ-002 Parameter POLY, default 8'h8E: Galois feedback mask XORed into the shifted state when the dropped LSB is 1.
REQ-003 Parameter SEED, default 8'h32: reset value and zero-seed substitute; SHALL be non-zero.
REQ-004 Parameter STEPS, default 1: LFSR advances per GEN cycle, legal 1..WIDTH.
REQ-005 Parameter MAX_TRIES, default 16: rejection limit before fallback, legal >= 1.
REQ-006 clk  input  1  single clock, rising edge.
REQ-007 rst  input  1  reset, asynchronous, active-high.
REQ-008 i_seed_load  input  1  load i_seed into LFSR state this cycle.
REQ-009 i_seed  input  WIDTH  seed value.
REQ-010 i_req  input  1  request one random value; sampled only in IDLE.
REQ-011 i_bound  input  WIDTH  exclusive upper bound; 0 = full range; sampled with i_req.
REQ-012 i_ready  input  1  consumer accepts o_random_data.
REQ-013 o_valid  output  1  o_random_data holds a result.
REQ-014 o_random_data  output  WIDTH  result, stable while o_valid=1.
REQ-015 o_busy  output  1  high in GEN.

Function
REQ-016 One step SHALL be next = (Q >> 1) ^ (Q[0] ? POLY : 0).
REQ-017 FSM states IDLE, GEN, HOLD; LFSR state Q changes only in GEN or on seed load.
REQ-018 IDLE & i_req: latch bound, compute mask = smallest 2^k-1 >= bound-1 (all-ones if bound=0), clear try counter, go GEN.
REQ-019 Each GEN cycle: Q <= STEPS steps of Q; candidate = new Q & mask.
REQ-020 Accept if bound=0 or candidate < bound: o_random_data <= candidate, o_valid <= 1, go HOLD.
REQ-021 Reject: if tries = MAX_TRIES-1, emit candidate & (mask >> 1) as accepted and go HOLD; else tries++ and stay GEN.
REQ-022 Bound=1 yields mask 0; result always 0 on first GEN cycle.
REQ-023 Latency: i_req sampled at edge N; earliest o_valid=1 after edge N+1; worst case after edge N+MAX_TRIES.
REQ-024 HOLD: o_valid and o_random_data held until i_ready=1; that edge clears o_valid, goes IDLE; i_req in that cycle is ignored.
REQ-025 i_seed_load has priority in every state: Q <= (i_seed = 0) ? SEED : i_seed; FSM -> IDLE, o_valid <= 0, pending request dropped.
REQ-026 Q SHALL never hold 0 (all-zero lock-up is impossible by REQ-025 and SEED non-zero).
REQ-027 o_busy = 1 exactly in GEN; i_bound changes outside IDLE have no effect.

Reset
REQ-028 rst=1 asynchronously forces Q=SEED, state IDLE, tries=0, o_valid=0, o_random_data=0, o_busy=0.
REQ-029 Reset mid-GEN or mid-HOLD discards the request; no output after release until a new i_req.

Structure
REQ-030 Shared package holds the FSM state enum and default POLY/SEED constants.
REQ-031 One combinational sub-module galois_lfsr_step (WIDTH, POLY) SHALL implement REQ-016; instantiated STEPS times in a chain.

Verification (WIDTH=8, POLY=8'h8E, SEED=8'h32, STEPS=1)
REQ-032 Reset, i_req with bound=0 -> o_valid after 2nd edge, data 0x19; next requests give 0x82, 0x41.
REQ-033 i_seed_load with i_seed=0x00 -> Q=0x32; request with bound=0 -> 0x19.
REQ-034 Load 0x41, request bound=6 -> candidates 6, 7 rejected, o_valid after 3 GEN cycles with data 5.
REQ-035 MAX_TRIES=1, load 0x41, bound=6 -> first candidate 6 rejected, fallback data 2 after 1 GEN cycle.
REQ-036 HOLD with i_ready=0 for 5 cycles -> data stable, o_valid high; i_seed_load during GEN -> o_valid stays 0, IDLE next cycle.
REQ-037 rst pulse during GEN -> all outputs 0 immediately, Q=0x32 after release.
